// File: rtl/control_main_vseq_pkg.sv
// Shared opcode, ALU-class and register-type codes for the ID-stage main control,
// plus the packed control word carried between decode and the vector sequencer.
package control_main_vseq_pkg;

    localparam logic [6:0] R_FORMAT      = 7'b0110011;
    localparam logic [6:0] I_COMP_FORMAT = 7'b0010011;
    localparam logic [6:0] I_LOAD_FORMAT = 7'b0000011;
    localparam logic [6:0] I_ENV_FORMAT  = 7'b1110011;
    localparam logic [6:0] JALR_FORMAT   = 7'b1100111;
    localparam logic [6:0] J_FORMAT      = 7'b1101111;
    localparam logic [6:0] S_FORMAT      = 7'b0100011;
    localparam logic [6:0] B_FORMAT      = 7'b1100011;
    localparam logic [6:0] LUI_FORMAT    = 7'b0110111;
    localparam logic [6:0] AUIPC_FORMAT  = 7'b0010111;
    localparam logic [6:0] VL_FORMAT     = 7'b0000111;
    localparam logic [6:0] VS_FORMAT     = 7'b0100111;

    localparam logic [2:0] ALU_R          = 3'd0;
    localparam logic [2:0] ALU_I_COMP     = 3'd1;
    localparam logic [2:0] ALU_LOAD_STORE = 3'd2;
    localparam logic [2:0] ALU_BRANCH     = 3'd3;
    localparam logic [2:0] ALU_LUI        = 3'd4;
    localparam logic [2:0] ALU_AUIPC      = 3'd5;
    localparam logic [2:0] ALU_J          = 3'd6;
    localparam logic [2:0] ALU_CSR        = 3'd7;

    localparam logic [1:0] REG_TYPE_X   = 2'b00;
    localparam logic [1:0] REG_TYPE_CSR = 2'b01;
    localparam logic [1:0] REG_TYPE_VEC = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       jump_jalr;
        logic       in_a_is_pc;
        logic [1:0] reg_type;
        logic [2:0] alu_cntrl;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c           = '0;
        c.reg_type  = REG_TYPE_X;
        c.alu_cntrl = ALU_R;
        return c;
    endfunction

    function automatic logic is_vec_mem(input logic [6:0] op);
        return (op == VL_FORMAT) || (op == VS_FORMAT);
    endfunction

endpackage

// File: rtl/control_decode_comb.sv
// Pure opcode -> control-word table; also used by the scalar pipeline, so it
// knows nothing about beats or stalls.
module control_decode_comb
    import control_main_vseq_pkg::*;
(
    input  logic              instr_valid,
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t c;

    always_comb begin
        c = bubble_ctrl();
        if (instr_valid) begin
            case (opcode)
                R_FORMAT: begin
                    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_cntrl = ALU_R;
                end
                I_COMP_FORMAT: begin
                    c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
                    c.alu_cntrl = ALU_I_COMP;
                end
                I_LOAD_FORMAT: begin
                    c.reg_dst = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
                    c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_cntrl = ALU_LOAD_STORE;
                end
                I_ENV_FORMAT: begin
                    c.reg_type = REG_TYPE_CSR; c.reg_dst = 1'b1; c.reg_write = 1'b1;
                    c.alu_cntrl = ALU_CSR;
                end
                JALR_FORMAT: begin
                    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.jump_jalr = 1'b1;
                    c.in_a_is_pc = 1'b1; c.alu_cntrl = ALU_J;
                end
                J_FORMAT: begin
                    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.jump = 1'b1;
                    c.in_a_is_pc = 1'b1; c.alu_cntrl = ALU_J;
                end
                S_FORMAT: begin
                    c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_cntrl = ALU_LOAD_STORE;
                end
                B_FORMAT: begin
                    c.branch = 1'b1; c.alu_cntrl = ALU_BRANCH;
                end
                LUI_FORMAT: begin
                    c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
                    c.alu_cntrl = ALU_LUI;
                end
                AUIPC_FORMAT: begin
                    c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
                    c.in_a_is_pc = 1'b1; c.alu_cntrl = ALU_AUIPC;
                end
                VL_FORMAT: begin
                    c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                    c.reg_dst = 1'b1; c.reg_type = REG_TYPE_VEC; c.alu_cntrl = ALU_LOAD_STORE;
                end
                VS_FORMAT: begin
                    c.mem_write = 1'b1; c.reg_type = REG_TYPE_VEC; c.alu_cntrl = ALU_LOAD_STORE;
                end
                default: c = bubble_ctrl();
            endcase
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/control_main_vseq.sv
// ID-stage main control: scalar opcodes pass straight through the decode table,
// vector loads/stores are expanded into one control beat per memory beat.
module control_main_vseq
    import control_main_vseq_pkg::*;
#(
    parameter  int VLEN     = 128,
    parameter  int ELEN     = 32,
    parameter  int BEAT_W   = 32,
    localparam int EPB      = BEAT_W / ELEN,
    localparam int MAXBEATS = VLEN / BEAT_W,
    localparam int VLMAX    = VLEN / ELEN,
    localparam int VLW      = $clog2(VLMAX + 1),
    localparam int BW       = $clog2(MAXBEATS + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           instr_valid,
    input  logic [6:0]     opcode,
    input  logic [VLW-1:0] vl,
    input  logic           mem_ready,
    output logic           RegDst,
    output logic           Branch,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemToReg,
    output logic           ALUSrc,
    output logic           RegWrite,
    output logic           Jump,
    output logic           JumpJALR,
    output logic           inA_is_PC,
    output logic [1:0]     reg_type,
    output logic [2:0]     ALUcntrl,
    output logic           vec_mem,
    output logic [BW-1:0]  beat_idx,
    output logic [EPB-1:0] beat_mask,
    output logic [31:0]    addr_off,
    output logic           last_beat,
    output logic           id_stall,
    output logic           busy
);

    localparam int EPB_SH  = $clog2(EPB);
    localparam int BYTE_SH = $clog2(BEAT_W / 8);

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_idx_q, beat_idx_d;
    logic [BW-1:0]  last_idx_q, last_idx_d;
    ctrl_t          op_q, op_d;
    logic [VLW-1:0] vl_q, vl_d;

    logic [CTRL_W-1:0] dec_bits;
    ctrl_t             dec_ctrl;
    ctrl_t             out_ctrl;
    logic              vec_op;
    logic              vec_accept;
    logic              last_run;
    logic [VLW-1:0]    vl_clamped;
    logic [VLW:0]      elem_ceil;
    logic [EPB-1:0]    mask_run;

    control_decode_comb u_decode (
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .ctrl        (dec_bits)
    );

    assign dec_ctrl   = ctrl_t'(dec_bits);
    assign vec_op     = instr_valid && is_vec_mem(opcode);
    assign vec_accept = vec_op && (vl != '0);
    assign vl_clamped = (vl > VLW'(VLMAX)) ? VLW'(VLMAX) : vl;
    // Rounded-up element count; shifting by EPB_SH then gives ceil(vl/EPB).
    assign elem_ceil  = {1'b0, vl_clamped} + (VLW+1)'(EPB - 1);
    assign last_run   = (beat_idx_q == last_idx_q);

    for (genvar gi = 0; gi < EPB; gi++) begin : g_mask
        assign mask_run[gi] = ((32'(beat_idx_q) << EPB_SH) + 32'(gi)) < 32'(vl_q);
    end

    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        last_idx_d = last_idx_q;
        op_d       = op_q;
        vl_d       = vl_q;
        case (state_q)
            ST_IDLE: begin
                if (vec_accept) begin
                    state_d    = ST_RUN;
                    beat_idx_d = '0;
                    op_d       = dec_ctrl;
                    vl_d       = vl_clamped;
                    last_idx_d = BW'((elem_ceil >> EPB_SH) - (VLW+1)'(1));
                end
            end
            ST_RUN: begin
                if (mem_ready) begin
                    if (last_run) begin
                        state_d    = ST_IDLE;
                        beat_idx_d = '0;
                    end else begin
                        beat_idx_d = beat_idx_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_idx_q <= '0;
            last_idx_q <= '0;
            op_q       <= bubble_ctrl();
            vl_q       <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            last_idx_q <= last_idx_d;
            op_q       <= op_d;
            vl_q       <= vl_d;
        end
    end

    // In RUN every output is a function of registered state plus mem_ready only,
    // so a stalled beat stays stable until the memory takes it.
    always_comb begin
        out_ctrl  = bubble_ctrl();
        vec_mem   = 1'b0;
        beat_idx  = '0;
        beat_mask = '0;
        addr_off  = '0;
        last_beat = 1'b0;
        id_stall  = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            if (state_q == ST_RUN) begin
                out_ctrl  = op_q;
                vec_mem   = 1'b1;
                beat_idx  = beat_idx_q;
                beat_mask = mask_run;
                addr_off  = 32'(beat_idx_q) << BYTE_SH;
                last_beat = last_run;
                id_stall  = !(last_run && mem_ready);
                busy      = 1'b1;
            end else if (vec_op) begin
                id_stall = vec_accept;
            end else begin
                out_ctrl = dec_ctrl;
            end
        end
    end

    assign RegDst    = out_ctrl.reg_dst;
    assign Branch    = out_ctrl.branch;
    assign MemRead   = out_ctrl.mem_read;
    assign MemWrite  = out_ctrl.mem_write;
    assign MemToReg  = out_ctrl.mem_to_reg;
    assign ALUSrc    = out_ctrl.alu_src;
    assign RegWrite  = out_ctrl.reg_write;
    assign Jump      = out_ctrl.jump;
    assign JumpJALR  = out_ctrl.jump_jalr;
    assign inA_is_PC = out_ctrl.in_a_is_pc;
    assign reg_type  = out_ctrl.reg_type;
    assign ALUcntrl  = out_ctrl.alu_cntrl;

endmodule

// File: tb/tb_control_main_vseq.sv
// Bench for control_main_vseq: a 32-bit-beat and a 64-bit-beat instance checked
// against a transaction-level model of decode, beat expansion and masking.
module tb_control_main_vseq;

    localparam logic [6:0] OP_R = 7'b0110011, OP_IC = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ENV = 7'b1110011, OP_JALR = 7'b1100111, OP_J = 7'b1101111;
    localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_VL = 7'b0000111, OP_VS = 7'b0100111;
    localparam logic [6:0] SC_OPS [10] = '{OP_R, OP_IC, OP_LD, OP_ENV, OP_JALR,
                                           OP_J, OP_S, OP_B, OP_LUI, OP_AUIPC};

    localparam logic [9:0] RD = 10'h200, BR = 10'h100, MR = 10'h080, MW = 10'h040;
    localparam logic [9:0] M2R = 10'h020, AS = 10'h010, RW = 10'h008, JP = 10'h004;
    localparam logic [9:0] JR = 10'h002, PC = 10'h001;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [1:0]  rt;
        logic [2:0]  alu;
        logic        vm;
        logic [2:0]  idx;
        logic [1:0]  mask;
        logic [31:0] addr;
        logic        last;
        logic        stall;
        logic        busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, instr_valid, mem_ready, sel;
    logic [6:0] opcode;
    logic [2:0] vl;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    logic [9:0]  ctl_a, ctl_b;
    logic [1:0]  rt_a, rt_b, idx_b, mask_b;
    logic [2:0]  alu_a, alu_b, idx_a;
    logic        vm_a, vm_b, mask_a, last_a, last_b, stall_a, stall_b, busy_a, busy_b;
    logic [31:0] addr_a, addr_b;
    obs_t        obs_a, obs_b, obs;

    control_main_vseq dut_a (
        .clock(clk), .reset(rst), .instr_valid(instr_valid & ~sel), .opcode(opcode),
        .vl(vl), .mem_ready(mem_ready),
        .RegDst(ctl_a[9]), .Branch(ctl_a[8]), .MemRead(ctl_a[7]), .MemWrite(ctl_a[6]),
        .MemToReg(ctl_a[5]), .ALUSrc(ctl_a[4]), .RegWrite(ctl_a[3]), .Jump(ctl_a[2]),
        .JumpJALR(ctl_a[1]), .inA_is_PC(ctl_a[0]),
        .reg_type(rt_a), .ALUcntrl(alu_a), .vec_mem(vm_a), .beat_idx(idx_a),
        .beat_mask(mask_a), .addr_off(addr_a), .last_beat(last_a), .id_stall(stall_a),
        .busy(busy_a)
    );

    control_main_vseq #(.BEAT_W(64)) dut_b (
        .clock(clk), .reset(rst), .instr_valid(instr_valid & sel), .opcode(opcode),
        .vl(vl), .mem_ready(mem_ready),
        .RegDst(ctl_b[9]), .Branch(ctl_b[8]), .MemRead(ctl_b[7]), .MemWrite(ctl_b[6]),
        .MemToReg(ctl_b[5]), .ALUSrc(ctl_b[4]), .RegWrite(ctl_b[3]), .Jump(ctl_b[2]),
        .JumpJALR(ctl_b[1]), .inA_is_PC(ctl_b[0]),
        .reg_type(rt_b), .ALUcntrl(alu_b), .vec_mem(vm_b), .beat_idx(idx_b),
        .beat_mask(mask_b), .addr_off(addr_b), .last_beat(last_b), .id_stall(stall_b),
        .busy(busy_b)
    );

    assign obs_a = {ctl_a, rt_a, alu_a, vm_a, idx_a, 1'b0, mask_a, addr_a, last_a, stall_a, busy_a};
    assign obs_b = {ctl_b, rt_b, alu_b, vm_b, 1'b0, idx_b, mask_b, addr_b, last_b, stall_b, busy_b};
    assign obs   = sel ? obs_b : obs_a;

    function automatic obs_t sc_exp(input logic v, input logic [6:0] op);
        obs_t e;
        e = '0;
        if (v) begin
            case (op)
                OP_R:     e.ctl = RD | RW;
                OP_IC:    begin e.ctl = RD | AS | RW; e.alu = 3'd1; end
                OP_LD:    begin e.ctl = RD | MR | M2R | AS | RW; e.alu = 3'd2; end
                OP_ENV:   begin e.ctl = RD | RW; e.rt = 2'b01; e.alu = 3'd7; end
                OP_JALR:  begin e.ctl = RD | RW | JR | PC; e.alu = 3'd6; end
                OP_J:     begin e.ctl = RD | RW | JP | PC; e.alu = 3'd6; end
                OP_S:     begin e.ctl = MW | AS; e.alu = 3'd2; end
                OP_B:     begin e.ctl = BR; e.alu = 3'd3; end
                OP_LUI:   begin e.ctl = RD | AS | RW; e.alu = 3'd4; end
                OP_AUIPC: begin e.ctl = RD | AS | RW | PC; e.alu = 3'd5; end
                default:  e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input obs_t e);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic step(input string tag, input obs_t e);
        @(negedge clk);
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_scalar(input string tag, input logic v, input logic [6:0] op);
        instr_valid = v;
        opcode      = op;
        vl          = 3'($urandom);
        mem_ready   = 1'($urandom);
        step(tag, sc_exp(v, op));
    endtask

    // One vector op: accept bubble, then ceil(vl/EPB) beats; pct is the chance (%)
    // of mem_ready=0 per cycle, hold_beat/hold_n force stalls, rst_beat aborts.
    task automatic do_vec(input string tag, input logic st, input logic s, input int v,
                          input int pct, input int hold_beat, input int hold_n,
                          input int rst_beat);
        int   epb, vc, nb, held;
        logic mr;
        obs_t e;
        sel         = s;
        epb         = s ? 2 : 1;
        vc          = (v > 4) ? 4 : v;
        nb          = (vc + epb - 1) / epb;
        instr_valid = 1'b1;
        opcode      = st ? OP_VS : OP_VL;
        vl          = 3'(v);
        mem_ready   = 1'($urandom);
        e           = '0;
        e.stall     = (vc != 0);
        step({tag, "_accept"}, e);
        for (int k = 0; k < nb; k++) begin
            if (k == rst_beat) begin
                rst       = 1'b1;
                mem_ready = 1'b1;
                step({tag, "_reset"}, obs_t'(0));
                rst = 1'b0;
                return;
            end
            held = 0;
            mr   = 1'b0;
            while (!mr) begin
                if (k == hold_beat && held < hold_n) mr = 1'b0;
                else if (held >= 20)                 mr = 1'b1;
                else                                 mr = ($urandom_range(99) >= pct);
                mem_ready   = mr;
                instr_valid = 1'($urandom);
                opcode      = 7'($urandom);
                vl          = 3'($urandom);
                e       = '0;
                e.ctl   = st ? MW : (RD | MR | M2R | RW);
                e.rt    = 2'b10;
                e.alu   = 3'd2;
                e.vm    = 1'b1;
                e.idx   = 3'(k);
                for (int i = 0; i < epb; i++) e.mask[i] = ((k * epb + i) < vc);
                e.addr  = 32'(k * (s ? 8 : 4));
                e.last  = (k == nb - 1);
                e.stall = !(e.last && mr);
                e.busy  = 1'b1;
                step($sformatf("%s_b%0d", tag, k), e);
                held++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] rop;
        rst = 1'b1; instr_valid = 1'b1; opcode = OP_R; vl = 3'd0; mem_ready = 1'b0; sel = 1'b0;
        @(posedge clk);
        #1;
        step("reset_out_a", obs_t'(0));
        sel = 1'b1;
        opcode = OP_LD;
        step("reset_out_b", obs_t'(0));
        rst = 1'b0;
        sel = 1'b0;

        do_scalar("t1_r", 1'b1, OP_R);
        do_scalar("t1_b", 1'b1, OP_B);
        do_vec("t2_vs4", 1'b1, 1'b0, 4, 0, -1, 0, -1);
        do_scalar("t2_next", 1'b1, OP_IC);
        do_vec("t3_vl3_w64", 1'b0, 1'b1, 3, 0, -1, 0, -1);
        do_scalar("t3_next", 1'b1, OP_J);
        do_vec("t4_hold", 1'b0, 1'b0, 4, 0, 1, 3, -1);
        do_scalar("t4_next", 1'b1, OP_ENV);
        do_vec("t5_vl0", 1'b1, 1'b0, 0, 0, -1, 0, -1);
        do_scalar("t5_next", 1'b1, OP_S);
        do_vec("t6_abort", 1'b0, 1'b0, 4, 0, -1, 0, 2);
        do_scalar("t6_next", 1'b1, OP_LD);
        do_vec("clamp_a", 1'b0, 1'b0, 7, 0, -1, 0, -1);
        do_vec("clamp_b", 1'b1, 1'b1, 6, 0, -1, 0, -1);
        do_vec("odd_b", 1'b1, 1'b1, 1, 0, 0, 2, -1);
        do_scalar("invalid", 1'b0, OP_R);
        do_scalar("jalr", 1'b1, OP_JALR);
        do_scalar("auipc", 1'b1, OP_AUIPC);
        do_scalar("lui", 1'b1, OP_LUI);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(3) == 0) begin
                do_vec("rnd_vec", 1'($urandom), 1'($urandom), int'($urandom_range(7)),
                       30, -1, 0, -1);
            end else begin
                rop = ($urandom_range(4) == 0) ? 7'($urandom) : SC_OPS[$urandom_range(9)];
                if (rop == OP_VL || rop == OP_VS) rop = OP_R;
                sel = 1'($urandom);
                do_scalar("rnd_sc", ($urandom_range(9) != 0), rop);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
